iic_master: RTL and testbench

IIC_MASTER -- requirements
Module: iic_master

---
 rtl/iic_master.sv | 271 +++++++++++++++++++++++++++
 tb/tb_iic_master.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/iic_master.sv
// I2C register-access master: START, device address, register address, then either
// a write burst or a repeated-START read burst, closed by STOP. SCL bits are split into 4 phases.
module iic_master #(
   parameter int CLK_DIV    = 125,
   parameter int ADDR_BYTES = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [6:0]  dev_addr,
   input  logic        rw,
   input  logic [15:0] reg_addr,
   input  logic [7:0]  len,
   input  logic [7:0]  wr_data,
   output logic        wr_req,
   output logic [7:0]  rd_data,
   output logic        rd_valid,
   output logic        busy,
   output logic        done,
   output logic        ack_err,
   output logic        iclk,
   inout  wire         sdata
);

   localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   localparam logic [3:0] S_IDLE   = 4'd0;
   localparam logic [3:0] S_START  = 4'd1;
   localparam logic [3:0] S_DEV_W  = 4'd2;
   localparam logic [3:0] S_REG    = 4'd3;
   localparam logic [3:0] S_WDATA  = 4'd4;
   localparam logic [3:0] S_RSTART = 4'd5;
   localparam logic [3:0] S_DEV_R  = 4'd6;
   localparam logic [3:0] S_RDATA  = 4'd7;
   localparam logic [3:0] S_STOP   = 4'd8;

   logic [3:0]       state_q, state_d;
   logic [DIV_W-1:0] div_q, div_d;
   logic [1:0]       phase_q, phase_d;
   logic [3:0]       bit_q, bit_d;
   logic [7:0]       byte_q, byte_d;
   logic [7:0]       tx_q, tx_d;
   logic [6:0]       rx_q, rx_d;
   logic [6:0]       dev_q, dev_d;
   logic             rw_q, rw_d;
   logic [15:0]      reg_q, reg_d;
   logic [7:0]       len_q, len_d;
   logic             nack_q, nack_d;
   logic             wr_req_q, wr_req_d;
   logic [7:0]       rd_data_q, rd_data_d;
   logic             rd_valid_q, rd_valid_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             ack_err_q, ack_err_d;

   logic phase_end, sample, bit_state, last_byte, scl, sda_low;

   assign phase_end = (div_q == DIV_W'(CLK_DIV - 1));
   assign sample    = (phase_q == 2'd2) && (div_q == '0);
   assign bit_state = (state_q == S_DEV_W) || (state_q == S_REG) || (state_q == S_WDATA) ||
                      (state_q == S_DEV_R) || (state_q == S_RDATA);
   assign last_byte = (byte_q == len_q - 8'd1);

   always_comb begin
      // NOTE: every _d starts from its _q (pulses from 0) so no branch leaves a latch behind.
      state_d    = state_q;
      div_d      = div_q;
      phase_d    = phase_q;
      bit_d      = bit_q;
      byte_d     = byte_q;
      tx_d       = tx_q;
      rx_d       = rx_q;
      dev_d      = dev_q;
      rw_d       = rw_q;
      reg_d      = reg_q;
      len_d      = len_q;
      nack_d     = nack_q;
      rd_data_d  = rd_data_q;
      busy_d     = busy_q;
      ack_err_d  = ack_err_q;
      wr_req_d   = 1'b0;
      rd_valid_d = 1'b0;
      done_d     = 1'b0;

      if (state_q == S_IDLE) begin
         div_d   = '0;
         phase_d = 2'd0;
         bit_d   = 4'd0;
         byte_d  = 8'd0;
         // The done cycle is still IDLE; refusing start there keeps start and done apart.
         if (start && !done_q) begin
            dev_d     = dev_addr;
            rw_d      = rw;
            reg_d     = reg_addr;
            len_d     = len;
            nack_d    = 1'b0;
            ack_err_d = 1'b0;
            busy_d    = 1'b1;
            state_d   = S_START;
         end
      end else begin
         div_d = phase_end ? '0 : div_q + 1'b1;
         if (phase_end) phase_d = phase_q + 2'd1;

         if (sample && bit_state) begin
            rx_d = {rx_q[5:0], sdata};
            if (bit_q == 4'd8 && state_q != S_RDATA && sdata) begin
               nack_d    = 1'b1;
               ack_err_d = 1'b1;
            end
            if (bit_q == 4'd7 && state_q == S_RDATA) begin
               rd_data_d  = {rx_q, sdata};
               rd_valid_d = 1'b1;
            end
         end

         if (wr_req_q) tx_d = wr_data;

         if (phase_end && phase_q == 2'd3) begin
            case (state_q)
               S_START: begin
                  state_d = S_DEV_W;
                  tx_d    = {dev_q, 1'b0};
                  bit_d   = 4'd0;
               end
               S_RSTART: begin
                  state_d = S_DEV_R;
                  tx_d    = {dev_q, 1'b1};
                  bit_d   = 4'd0;
               end
               S_STOP: begin
                  state_d = S_IDLE;
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
               end
               default: begin
                  if (bit_q != 4'd8) begin
                     bit_d = bit_q + 4'd1;
                     tx_d  = {tx_q[6:0], 1'b0};
                  end else begin
                     bit_d = 4'd0;
                     if (nack_q) begin
                        state_d = S_STOP;
                     end else begin
                        case (state_q)
                           S_DEV_W: begin
                              state_d = S_REG;
                              byte_d  = 8'd0;
                              tx_d    = (ADDR_BYTES == 2) ? reg_q[15:8] : reg_q[7:0];
                           end
                           S_REG: begin
                              if (byte_q != 8'(ADDR_BYTES - 1)) begin
                                 byte_d = byte_q + 8'd1;
                                 tx_d   = reg_q[7:0];
                              end else if (len_q == 8'd0) begin
                                 state_d = S_STOP;
                              end else if (rw_q) begin
                                 state_d = S_RSTART;
                              end else begin
                                 state_d  = S_WDATA;
                                 byte_d   = 8'd0;
                                 wr_req_d = 1'b1;
                              end
                           end
                           S_WDATA: begin
                              if (last_byte) begin
                                 state_d = S_STOP;
                              end else begin
                                 byte_d   = byte_q + 8'd1;
                                 wr_req_d = 1'b1;
                              end
                           end
                           S_DEV_R: begin
                              state_d = S_RDATA;
                              byte_d  = 8'd0;
                           end
                           default: begin
                              if (last_byte) state_d = S_STOP;
                              else           byte_d  = byte_q + 8'd1;
                           end
                        endcase
                     end
                  end
               end
            endcase
         end
      end
   end

   // Bus pins decoded from state and phase: (R)START pull SDA in P2/P3, STOP releases it in P2.
   always_comb begin
      scl     = 1'b1;
      sda_low = 1'b0;
      case (state_q)
         S_IDLE: begin
            scl     = 1'b1;
            sda_low = 1'b0;
         end
         S_START: begin
            scl     = (phase_q != 2'd3);
            sda_low = phase_q[1];
         end
         S_RSTART: begin
            scl     = (phase_q == 2'd1) || (phase_q == 2'd2);
            sda_low = phase_q[1];
         end
         S_STOP: begin
            scl     = (phase_q != 2'd0);
            sda_low = !phase_q[1];
         end
         default: begin
            scl = (phase_q == 2'd1) || (phase_q == 2'd2);
            if (bit_q == 4'd8) sda_low = (state_q == S_RDATA) && !last_byte;
            else               sda_low = (state_q != S_RDATA) && !tx_q[7];
         end
      endcase
   end

   always_ff @(posedge clk) begin
      // NOTE: state updates use non-blocking assignments; reset is synchronous and wins over everything.
      if (rst) begin
         state_q    <= S_IDLE;
         div_q      <= '0;
         phase_q    <= 2'd0;
         bit_q      <= 4'd0;
         byte_q     <= 8'd0;
         tx_q       <= 8'd0;
         rx_q       <= 7'd0;
         dev_q      <= 7'd0;
         rw_q       <= 1'b0;
         reg_q      <= 16'd0;
         len_q      <= 8'd0;
         nack_q     <= 1'b0;
         wr_req_q   <= 1'b0;
         rd_data_q  <= 8'd0;
         rd_valid_q <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         ack_err_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         div_q      <= div_d;
         phase_q    <= phase_d;
         bit_q      <= bit_d;
         byte_q     <= byte_d;
         tx_q       <= tx_d;
         rx_q       <= rx_d;
         dev_q      <= dev_d;
         rw_q       <= rw_d;
         reg_q      <= reg_d;
         len_q      <= len_d;
         nack_q     <= nack_d;
         wr_req_q   <= wr_req_d;
         rd_data_q  <= rd_data_d;
         rd_valid_q <= rd_valid_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         ack_err_q  <= ack_err_d;
      end
   end

   assign iclk     = scl;
   assign sdata    = sda_low ? 1'b0 : 1'bz;
   assign wr_req   = wr_req_q;
   assign rd_data  = rd_data_q;
   assign rd_valid = rd_valid_q;
   assign busy     = busy_q;
   assign done     = done_q;
   assign ack_err  = ack_err_q;

endmodule

// File: tb/tb_iic_master.sv
// Bench for iic_master: behavioural I2C slave plus bus logger on two instances
// (1- and 2-byte register address), table-driven transactions and hand-written corner cases.
module tb_iic_master;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start1 = 1'b0, start2 = 1'b0;
   logic [6:0]  dev_addr = 7'd0;
   logic        rw = 1'b0;
   logic [15:0] reg_addr = 16'd0;
   logic [7:0]  len = 8'd0;
   logic [7:0]  wr_data = 8'd0;

   logic        wr_req1, rd_valid1, busy1, done1, ack_err1, iclk1;
   logic [7:0]  rd_data1;
   logic        wr_req2, rd_valid2, busy2, done2, ack_err2, iclk2;
   logic [7:0]  rd_data2;
   wire         sda1, sda2;

   pullup (sda1);
   pullup (sda2);

   logic slave_low [2];
   assign sda1 = slave_low[0] ? 1'b0 : 1'bz;
   assign sda2 = slave_low[1] ? 1'b0 : 1'bz;

   always #5 clk = ~clk;

   iic_master #(.CLK_DIV(4), .ADDR_BYTES(1)) dut (
      .clk(clk), .rst(rst), .start(start1), .dev_addr(dev_addr), .rw(rw),
      .reg_addr(reg_addr), .len(len), .wr_data(wr_data), .wr_req(wr_req1),
      .rd_data(rd_data1), .rd_valid(rd_valid1), .busy(busy1), .done(done1),
      .ack_err(ack_err1), .iclk(iclk1), .sdata(sda1));

   iic_master #(.CLK_DIV(4), .ADDR_BYTES(2)) dut2 (
      .clk(clk), .rst(rst), .start(start2), .dev_addr(dev_addr), .rw(rw),
      .reg_addr(reg_addr), .len(len), .wr_data(wr_data), .wr_req(wr_req2),
      .rd_data(rd_data2), .rd_valid(rd_valid2), .busy(busy2), .done(done2),
      .ack_err(ack_err2), .iclk(iclk2), .sdata(sda2));

   typedef struct {
      logic [6:0]  dev;
      logic        rw;
      logic [15:0] reg_addr;
      logic [7:0]  len;
      logic [23:0] data;     // byte 0 in [23:16]: write data or slave read data
      logic        nack;     // slave NACKs the device-address byte
      logic        exp_err;
      int          exp_wr;
      int          exp_rd;
   } txn_t;

   int checks = 0;
   int errors = 0;

   // Slave configuration (written by the test) and bus-side state (written by the monitor).
   logic        nack_dev = 1'b0;
   logic [23:0] rd_src = 24'd0;
   logic [23:0] wdat = 24'd0;
   int          wr_base = 0;

   // Log entry: bit 15 = instance, 0x1000 = (re)START, 0x2000 = STOP, else {byte, ack bit}.
   logic [15:0] bus_log [$];
   logic [15:0] exp_q [$];
   logic [7:0]  rd_vals [$];
   int          done_cnt [2];
   int          wr_cnt [2];
   int          rd_cnt [2];
   int          bitn [2];
   int          seg [2];
   logic [8:0]  sr [2];
   logic        addr_rw [2];
   logic        rd_stop [2];
   logic        prev_scl [2];
   logic        prev_sda [2];

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic bus_step(input int g, input logic scl, input logic sda);
      logic [15:0] tag;
      tag = (g == 0) ? 16'h0000 : 16'h8000;
      if (scl && prev_scl[g] && prev_sda[g] && !sda) begin
         bus_log.push_back(tag | 16'h1000);
         bitn[g] = 0; seg[g] = 0; addr_rw[g] = 1'b0; rd_stop[g] = 1'b0; slave_low[g] = 1'b0;
      end else if (scl && prev_scl[g] && !prev_sda[g] && sda) begin
         bus_log.push_back(tag | 16'h2000);
         slave_low[g] = 1'b0;
      end else if (scl && !prev_scl[g]) begin
         sr[g] = {sr[g][7:0], sda};
         bitn[g]++;
         if (bitn[g] == 8 && seg[g] == 0) addr_rw[g] = sda;
         if (bitn[g] == 9) begin
            bus_log.push_back(tag | {7'd0, sr[g]});
            if (addr_rw[g] && seg[g] > 0 && sda) rd_stop[g] = 1'b1;
         end
      end else if (!scl && prev_scl[g]) begin
         if (bitn[g] == 9) begin
            bitn[g] = 0;
            seg[g]++;
         end
         if (bitn[g] == 8)
            slave_low[g] = !(addr_rw[g] && seg[g] > 0) && !(seg[g] == 0 && nack_dev);
         else if (bitn[g] < 8 && addr_rw[g] && seg[g] > 0 && seg[g] <= 3 && !rd_stop[g])
            slave_low[g] = !rd_src[23 - 8 * (seg[g] - 1) - bitn[g]];
         else
            slave_low[g] = 1'b0;
      end
      prev_scl[g] = scl;
      prev_sda[g] = sda;
   endtask

   always @(negedge clk) begin
      int k;
      bus_step(0, iclk1, sda1 !== 1'b0);
      bus_step(1, iclk2, sda2 !== 1'b0);
      if (done1) done_cnt[0]++;
      if (done2) done_cnt[1]++;
      if (wr_req1) begin
         k = wr_cnt[0] - wr_base;
         wr_data = (k >= 0 && k < 3) ? wdat[23 - 8 * k -: 8] : 8'h00;
         wr_cnt[0]++;
      end
      if (wr_req2) wr_cnt[1]++;
      if (rd_valid1) begin
         rd_vals.push_back(rd_data1);
         rd_cnt[0]++;
      end
      if (rd_valid2) rd_cnt[1]++;
   end

   // Expected bus picture of one transaction, built from the transaction record.
   task automatic build_exp(input txn_t t, input int g, input int abytes);
      logic [15:0] tag;
      logic [7:0]  b;
      tag = (g == 0) ? 16'h0000 : 16'h8000;
      exp_q.delete();
      exp_q.push_back(tag | 16'h1000);
      exp_q.push_back(tag | {7'd0, t.dev, 1'b0, t.nack});
      if (t.nack) begin
         exp_q.push_back(tag | 16'h2000);
         return;
      end
      if (abytes == 2) exp_q.push_back(tag | {7'd0, t.reg_addr[15:8], 1'b0});
      exp_q.push_back(tag | {7'd0, t.reg_addr[7:0], 1'b0});
      if (t.len != 0 && t.rw) begin
         exp_q.push_back(tag | 16'h1000);
         exp_q.push_back(tag | {7'd0, t.dev, 1'b1, 1'b0});
      end
      for (int i = 0; i < int'(t.len); i++) begin
         b = t.data[23 - 8 * i -: 8];
         exp_q.push_back(tag | {7'd0, b, (t.rw && i == int'(t.len) - 1)});
      end
      exp_q.push_back(tag | 16'h2000);
   endtask

   task automatic run_txn(input txn_t t, input int g, input bit poke);
      int  lb, db, wb, rb, rvb;
      bit  seen;
      nack_dev = t.nack;
      rd_src   = t.data;
      wdat     = t.data;
      wr_base  = wr_cnt[0];
      build_exp(t, g, (g == 0) ? 1 : 2);
      lb = bus_log.size(); db = done_cnt[g]; wb = wr_cnt[g]; rb = rd_cnt[g]; rvb = rd_vals.size();
      @(negedge clk);
      dev_addr = t.dev; rw = t.rw; reg_addr = t.reg_addr; len = t.len;
      if (g == 0) start1 = 1'b1; else start2 = 1'b1;
      @(negedge clk);
      start1 = 1'b0; start2 = 1'b0;
      dev_addr = ~t.dev; rw = ~t.rw; reg_addr = ~t.reg_addr; len = ~t.len;
      check("busy_after_start", (g == 0) ? busy1 : busy2, 1);
      seen = 1'b0;
      for (int i = 0; i < 8000; i++) begin
         @(negedge clk);
         if (poke && i == 300) begin
            start1 = 1'b1; dev_addr = 7'h11; rw = 1'b1; len = 8'd5;
         end
         if (poke && i == 301) start1 = 1'b0;
         if ((g == 0) ? done1 : done2) begin
            seen = 1'b1;
            break;
         end
      end
      check("done_seen", int'(seen), 1);
      check("ack_err_at_done", (g == 0) ? ack_err1 : ack_err2, t.exp_err);
      if (poke) begin
         start1 = 1'b1;
         @(negedge clk);
         start1 = 1'b0;
      end
      repeat (40) @(negedge clk);
      check("done_count", done_cnt[g] - db, 1);
      check("busy_after_done", (g == 0) ? busy1 : busy2, 0);
      check("ack_err_held", (g == 0) ? ack_err1 : ack_err2, t.exp_err);
      check("idle_scl", (g == 0) ? iclk1 : iclk2, 1);
      check("idle_sda", (g == 0) ? int'(sda1 !== 1'b0) : int'(sda2 !== 1'b0), 1);
      check("wr_req_count", wr_cnt[g] - wb, t.exp_wr);
      check("rd_valid_count", rd_cnt[g] - rb, t.exp_rd);
      for (int i = 0; i < t.exp_rd; i++)
         check("rd_data", (rvb + i < rd_vals.size()) ? int'(rd_vals[rvb + i]) : -1,
               int'(t.data[23 - 8 * i -: 8]));
      check("bus_length", bus_log.size() - lb, exp_q.size());
      for (int i = 0; i < exp_q.size(); i++)
         check("bus_item", (lb + i < bus_log.size()) ? int'(bus_log[lb + i]) : -1, int'(exp_q[i]));
   endtask

   txn_t tab [7];
   txn_t t2;

   initial begin
      int db, n;
      bit hit;
      tab[0] = '{7'h50, 1'b0, 16'h0010, 8'd2, 24'hA53C00, 1'b0, 1'b0, 2, 0};
      tab[1] = '{7'h50, 1'b1, 16'h0020, 8'd3, 24'h112233, 1'b0, 1'b0, 0, 3};
      tab[2] = '{7'h50, 1'b0, 16'h0010, 8'd2, 24'hA53C00, 1'b1, 1'b1, 0, 0};
      tab[3] = '{7'h2A, 1'b0, 16'h00FF, 8'd1, 24'h810000, 1'b0, 1'b0, 1, 0};
      tab[4] = '{7'h33, 1'b1, 16'h0042, 8'd0, 24'h000000, 1'b0, 1'b0, 0, 0};
      tab[5] = '{7'h7F, 1'b1, 16'h0001, 8'd1, 24'hC60000, 1'b0, 1'b0, 0, 1};
      tab[6] = '{7'h50, 1'b1, 16'h0020, 8'd2, 24'h5566AA, 1'b1, 1'b1, 0, 0};
      t2     = '{7'h50, 1'b0, 16'h1234, 8'd0, 24'h000000, 1'b0, 1'b0, 0, 0};

      repeat (3) @(negedge clk);
      check("rst_iclk", iclk1, 1);
      check("rst_sda", int'(sda1 !== 1'b0), 1);
      check("rst_busy", busy1, 0);
      check("rst_done", done1, 0);
      check("rst_wr_req", wr_req1, 0);
      check("rst_rd_valid", rd_valid1, 0);
      check("rst_ack_err", ack_err1, 0);
      check("rst_rd_data", rd_data1, 0);
      rst = 1'b0;
      repeat (3) @(negedge clk);

      for (int i = 0; i < 7; i++) run_txn(tab[i], 0, 1'b0);

      run_txn(t2, 1, 1'b0);

      // Abort during the second write byte; no STOP-driven done may follow.
      nack_dev = 1'b0; wdat = tab[0].data; wr_base = wr_cnt[0];
      db = done_cnt[0];
      @(negedge clk);
      dev_addr = tab[0].dev; rw = 1'b0; reg_addr = tab[0].reg_addr; len = tab[0].len; start1 = 1'b1;
      @(negedge clk);
      start1 = 1'b0;
      n = 0; hit = 1'b0;
      for (int i = 0; i < 8000; i++) begin
         @(negedge clk);
         if (wr_req1) n++;
         if (n == 2) begin
            hit = 1'b1;
            break;
         end
      end
      check("abort_reached_byte1", int'(hit), 1);
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("abort_busy", busy1, 0);
      check("abort_iclk", iclk1, 1);
      check("abort_sda", int'(sda1 !== 1'b0), 1);
      check("abort_done", done1, 0);
      rst = 1'b0;
      repeat (50) @(negedge clk);
      check("abort_no_done", done_cnt[0] - db, 0);
      run_txn(tab[0], 0, 1'b0);

      // start mid-transaction and on the done cycle must both be ignored.
      run_txn(tab[0], 0, 1'b1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
